fifo_sync_ctrl: RTL and testbench
=================================

Name: fifo_sync_ctrl

Overview:
- Single-clock pointer and flag controller for the team's dual-port FIFO memory.
- Accepts push/pop requests and drives the memory's write enable, write address, read enable and read address.
- Produces full/empty/almost flags, occupancy count and a read-data-valid strobe aligned to the memory's registered read output.
- Sits between a producer/consumer pair and the memory instance inside a single-clock FIFO wrapper.

Parameters:
- ADDR_WIDTH, 6, memory address width; DEPTH = 2**ADDR_WIDTH entries.
- AF_MARGIN, 4, almost_full asserts when count >= DEPTH-AF_MARGIN; legal range 1..DEPTH-1.
- AE_MARGIN, 4, almost_empty asserts when count <= AE_MARGIN; legal range 1..DEPTH-1.

Ports:
- clk  input  1  single clock for all state.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  producer write request.
- pop  input  1  consumer read request.
- flush  input  1  synchronous clear of FIFO contents.
- clr_err  input  1  synchronous clear of sticky error flags.
- mem_wr_en  output  1  write enable to memory.
- mem_waddr  output  ADDR_WIDTH  write address to memory.
- mem_rd_en  output  1  read enable to memory.
- mem_raddr  output  ADDR_WIDTH  read address to memory.
- rd_valid  output  1  memory data_out holds popped word this cycle.
- full  output  1  DEPTH entries held.
- empty  output  1  zero entries held.
- almost_full  output  1  threshold flag.
- almost_empty  output  1  threshold flag.
- count  output  ADDR_WIDTH+1  occupancy, range 0..DEPTH.
- overflow  output  1  sticky: push seen while full.
- underflow  output  1  sticky: pop seen while empty.

Behaviour:
- Pointers: wptr and rptr are ADDR_WIDTH+1 bits, incremented mod 2**(ADDR_WIDTH+1).
  - mem_waddr = wptr[ADDR_WIDTH-1:0]; mem_raddr = rptr[ADDR_WIDTH-1:0].
- Flags derive only from registered pointers, so they carry no combinational path from push/pop.
  - empty = (wptr == rptr).
  - full = MSBs differ and lower bits equal.
  - count = wptr - rptr.
- Accept: push_ok = push & ~full & ~flush; pop_ok = pop & ~empty & ~flush.
  - mem_wr_en = push_ok and mem_rd_en = pop_ok, both combinational in the same cycle.
  - Pointers advance on the clk edge at which the corresponding _ok is high.
- Read latency: rd_valid is registered and equals pop_ok delayed by 1 cycle, matching the memory's registered read.
- Simultaneous push and pop:
  - Not full, not empty: both accepted, count unchanged.
  - Full: pop accepted, push rejected, because full is evaluated before the pop takes effect.
  - Empty: push accepted, pop rejected. There is no write-to-read bypass.
- Wrap-around: after DEPTH pushes from reset, wptr = DEPTH and mem_waddr = 0, so full = 1.
- Error flags:
  - overflow sets on push & full & ~flush.
  - underflow sets on pop & empty & ~flush.
  - Both hold until clr_err or rst. A set event in the same cycle as clr_err takes priority (flag = 1).
- flush: next edge sets wptr = rptr = 0 and rd_valid = 0. Sticky errors are unaffected. flush overrides push/pop.
- Reset (async, immediate on rst high):
  - wptr = rptr = 0, rd_valid = 0, overflow = underflow = 0.
  - Resulting outputs: empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0.
  - mem_wr_en = mem_rd_en = 0 while rst is high.
  - Reset mid-operation discards contents; a pending rd_valid is cancelled.

Optional Feature:
- Macro: FIFO_SYNC_CTRL_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt (16 bits), reset to 0.
  - Increments by 1 per cycle with a rejected push or rejected pop (flush excluded). A cycle rejecting both increments by 2.
  - Saturates at 16'hFFFF; clr_err zeroes it.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset → empty = 1, full = 0, count = 0, almost_empty = 1, rd_valid = 0, mem_waddr = mem_raddr = 0.
- Push 64 consecutive cycles (ADDR_WIDTH = 6) → count = 60 sets almost_full; after the 64th push, full = 1, count = 64, mem_waddr = 0.
  - A 65th push → mem_wr_en = 0 and overflow = 1.
- From full, push + pop together → pop accepted, push rejected, count = 63, full = 0.
  - rd_valid = 1 on the next cycle with the read address of the oldest entry.
- From empty, push + pop together → push accepted, pop rejected, count = 1, underflow = 1.
  - clr_err the next cycle → underflow = 0.
- Fill to 10, then flush asserted with push + pop → next cycle count = 0, empty = 1, mem_wr_en = mem_rd_en = 0 during flush, rd_valid = 0.
- With count = 5 and a pop accepted, assert rst asynchronously → outputs go to reset values immediately and the expected rd_valid does not appear.
  - With FIFO_SYNC_CTRL_DROP_CNT_EN defined: 3 rejected pops on empty → drop_cnt = 3.

Source files
------------

// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: single-clock pointer, flag and error controller for a dual-port FIFO memory.
// Define FIFO_SYNC_CTRL_DROP_CNT_EN to add the saturating drop_cnt output.
module fifo_sync_ctrl #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned AF_MARGIN  = 4,
    parameter int unsigned AE_MARGIN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`ifdef FIFO_SYNC_CTRL_DROP_CNT_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);
    localparam logic [PW-1:0] AE_LEVEL = PW'(AE_MARGIN);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;
    logic          push_rej;
    logic          pop_rej;

    // Status flags come only from the registered pointers.
    assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    assign empty = (wptr == rptr);
    assign count = wptr - rptr;

    assign almost_full  = (count >= AF_LEVEL);
    assign almost_empty = (count <= AE_LEVEL);

    // Memory strobes are suppressed during reset so no write lands while state is cleared.
    assign push_ok  = push & ~full  & ~flush & ~rst;
    assign pop_ok   = pop  & ~empty & ~flush & ~rst;
    assign push_rej = push & full  & ~flush;
    assign pop_rej  = pop  & empty & ~flush;

    assign mem_wr_en = push_ok;
    assign mem_rd_en = pop_ok;
    assign mem_waddr = wptr[ADDR_WIDTH-1:0];
    assign mem_raddr = rptr[ADDR_WIDTH-1:0];

    // Pointers and read-valid pipeline; flush returns both pointers to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            rd_valid <= 1'b0;
        end else begin
            wptr     <= wptr + PW'(push_ok);
            rptr     <= rptr + PW'(pop_ok);
            rd_valid <= pop_ok;
        end
    end

    // Sticky errors: a new error in the clearing cycle wins over clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push_rej | (overflow  & ~clr_err);
            underflow <= pop_rej  | (underflow & ~clr_err);
        end
    end

`ifdef FIFO_SYNC_CTRL_DROP_CNT_EN
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    assign drop_inc = {1'b0, push_rej} + {1'b0, pop_rej};
    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (clr_err) begin
            drop_cnt <= '0;
        end else if (drop_sum[16]) begin
            drop_cnt <= 16'hFFFF;
        end else begin
            drop_cnt <= drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb_fifo_sync_ctrl: directed scenarios plus randomized traffic against an occupancy/address model.
// Define FIFO_SYNC_CTRL_DROP_CNT_EN for both files to also cover drop_cnt.
module tb_fifo_sync_ctrl;

    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AFM   = 4;
    localparam int unsigned AEM   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic          mem_wr_en, mem_rd_en, rd_valid;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   count;
`ifdef FIFO_SYNC_CTRL_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: occupancy, next addresses, sticky flags, pending read-valid.
    int m_cnt = 0, m_wa = 0, m_ra = 0, m_drop = 0;
    bit m_ov = 0, m_un = 0, m_rv = 0;

    fifo_sync_ctrl #(.ADDR_WIDTH(AW), .AF_MARGIN(AFM), .AE_MARGIN(AEM)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
        .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr), .mem_rd_en(mem_rd_en),
        .mem_raddr(mem_raddr), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
`ifdef FIFO_SYNC_CTRL_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached (tests=%0d)", tests);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_cnt = 0; m_wa = 0; m_ra = 0; m_drop = 0;
        m_ov = 0; m_un = 0; m_rv = 0;
    endtask

    task automatic model_step();
        bit p_ok, q_ok, p_rej, q_rej;
        p_ok  = push && (m_cnt < DEPTH) && !flush;
        q_ok  = pop  && (m_cnt > 0)     && !flush;
        p_rej = push && (m_cnt == DEPTH) && !flush;
        q_rej = pop  && (m_cnt == 0)     && !flush;
        if (flush) begin
            m_cnt = 0; m_wa = 0; m_ra = 0; m_rv = 0;
        end else begin
            m_cnt = m_cnt + int'(p_ok) - int'(q_ok);
            m_wa  = (m_wa + int'(p_ok)) % DEPTH;
            m_ra  = (m_ra + int'(q_ok)) % DEPTH;
            m_rv  = q_ok;
        end
        m_ov = p_rej || (m_ov && !clr_err);
        m_un = q_rej || (m_un && !clr_err);
        if (clr_err) m_drop = 0;
        else m_drop = (m_drop + int'(p_rej) + int'(q_rej) > 65535) ? 65535
                                                                    : m_drop + int'(p_rej) + int'(q_rej);
    endtask

    task automatic drive(input bit p, input bit q, input bit f, input bit c);
        @(negedge clk);
        push = p; pop = q; flush = f; clr_err = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 0);
        tests++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
            fails++; $display("FAIL reset_flags: got e/f/ae/af=%b exp 1010", {empty, full, almost_empty, almost_full});
        end
        tests++; if (count !== '0 || rd_valid !== 1'b0) begin
            fails++; $display("FAIL reset_count: got count=%0d rd_valid=%b exp 0/0", count, rd_valid);
        end
        tests++; if (mem_waddr !== '0 || mem_raddr !== '0) begin
            fails++; $display("FAIL reset_addr: got waddr=%0d raddr=%0d exp 0/0", mem_waddr, mem_raddr);
        end
        tests++; if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            fails++; $display("FAIL reset_strobes: got wr=%b rd=%b ov=%b un=%b exp 0000", mem_wr_en, mem_rd_en, overflow, underflow);
        end
        tick();
        drive(0, 0, 0, 0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 0, 0);
            tests++; if (almost_full !== (i >= DEPTH - AFM) || mem_wr_en !== 1'b1 || mem_waddr !== AW'(i)) begin
                fails++; $display("FAIL fill_%0d: got af=%b wr=%b waddr=%0d exp af=%b wr=1 waddr=%0d",
                                  i, almost_full, mem_wr_en, mem_waddr, (i >= DEPTH - AFM), i);
            end
            tick();
        end
        drive(1, 0, 0, 0);
        tests++; if (full !== 1'b1 || count !== 7'd64 || mem_waddr !== '0 || mem_wr_en !== 1'b0) begin
            fails++; $display("FAIL fill_full: got full=%b count=%0d waddr=%0d wr=%b exp 1/64/0/0", full, count, mem_waddr, mem_wr_en);
        end
        tick();
    endtask

    task automatic test_full_pushpop();
        drive(1, 1, 0, 0);
        tests++; if (overflow !== 1'b1 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b1 || mem_raddr !== '0) begin
            fails++; $display("FAIL full_pp: got ov=%b wr=%b rd=%b raddr=%0d exp 1/0/1/0", overflow, mem_wr_en, mem_rd_en, mem_raddr);
        end
        tick();
        drive(0, 0, 0, 1);
        tests++; if (count !== 7'd63 || full !== 1'b0 || rd_valid !== 1'b1) begin
            fails++; $display("FAIL full_pp_after: got count=%0d full=%b rv=%b exp 63/0/1", count, full, rd_valid);
        end
        tick();
        drive(0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        tests++; if (overflow !== 1'b0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
            fails++; $display("FAIL clr_flush: got ov=%b empty=%b rv=%b exp 0/1/0", overflow, empty, rd_valid);
        end
        tick();
    endtask

    task automatic test_empty_pushpop();
        drive(1, 1, 0, 0);
        tests++; if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0) begin
            fails++; $display("FAIL empty_pp: got wr=%b rd=%b exp 1/0", mem_wr_en, mem_rd_en);
        end
        tick();
        drive(0, 0, 0, 1);
        tests++; if (count !== 7'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin
            fails++; $display("FAIL empty_pp_after: got count=%0d un=%b rv=%b exp 1/1/0", count, underflow, rd_valid);
        end
        tick();
        drive(0, 0, 0, 0);
        tests++; if (underflow !== 1'b0) begin
            fails++; $display("FAIL clr_err: got un=%b exp 0", underflow);
        end
        tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 0, 0);
            tick();
        end
        drive(1, 1, 1, 0);
        tests++; if (count !== 7'd10 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
            fails++; $display("FAIL flush_during: got count=%0d wr=%b rd=%b exp 10/0/0", count, mem_wr_en, mem_rd_en);
        end
        tick();
        drive(0, 0, 0, 0);
        tests++; if (count !== '0 || empty !== 1'b1 || rd_valid !== 1'b0 || mem_waddr !== '0) begin
            fails++; $display("FAIL flush_after: got count=%0d empty=%b rv=%b waddr=%0d exp 0/1/0/0", count, empty, rd_valid, mem_waddr);
        end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0);
            tick();
        end
        drive(0, 1, 0, 0);
        tests++; if (count !== 7'd5 || mem_rd_en !== 1'b1) begin
            fails++; $display("FAIL arst_pre: got count=%0d rd=%b exp 5/1", count, mem_rd_en);
        end
        #2 rst = 1'b1;
        #1;
        tests++; if (count !== '0 || empty !== 1'b1 || almost_empty !== 1'b1 || mem_rd_en !== 1'b0 || mem_waddr !== '0) begin
            fails++; $display("FAIL arst_now: got count=%0d empty=%b ae=%b rd=%b waddr=%0d exp 0/1/1/0/0",
                              count, empty, almost_empty, mem_rd_en, mem_waddr);
        end
        tick();
        drive(0, 0, 0, 0);
        tests++; if (rd_valid !== 1'b0 || count !== '0) begin
            fails++; $display("FAIL arst_rv: got rv=%b count=%0d exp 0/0", rd_valid, count);
        end
        rst = 1'b0;
        tick();
    endtask

`ifdef FIFO_SYNC_CTRL_DROP_CNT_EN
    task automatic test_drop();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        tests++; if (drop_cnt !== 16'd3) begin
            fails++; $display("FAIL drop_cnt: got %0d exp 3", drop_cnt);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        int pp;
        logic [6:0] exp_flags;
        logic [6:0] got_flags;
        for (int n = 0; n < 2400; n++) begin
            pp = ((n / 150) % 2 == 0) ? 85 : 15;
            drive($urandom_range(0, 99) < pp, $urandom_range(0, 99) < (100 - pp),
                  $urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0);
            exp_flags = {m_cnt == DEPTH, m_cnt == 0, m_cnt >= DEPTH - AFM, m_cnt <= AEM, m_ov, m_un, m_rv};
            got_flags = {full, empty, almost_full, almost_empty, overflow, underflow, rd_valid};
            tests++; if (got_flags !== exp_flags || count !== (AW + 1)'(m_cnt)) begin
                fails++; $display("FAIL rnd_flags cyc %0d: got f/e/af/ae/ov/un/rv=%b count=%0d exp %b count=%0d",
                                  n, got_flags, count, exp_flags, m_cnt);
            end
            tests++; if (mem_wr_en !== (push && m_cnt < DEPTH && !flush) || mem_waddr !== AW'(m_wa)) begin
                fails++; $display("FAIL rnd_wr cyc %0d: got wr=%b waddr=%0d exp wr=%b waddr=%0d",
                                  n, mem_wr_en, mem_waddr, (push && m_cnt < DEPTH && !flush), m_wa);
            end
            tests++; if (mem_rd_en !== (pop && m_cnt > 0 && !flush) || mem_raddr !== AW'(m_ra)) begin
                fails++; $display("FAIL rnd_rd cyc %0d: got rd=%b raddr=%0d exp rd=%b raddr=%0d",
                                  n, mem_rd_en, mem_raddr, (pop && m_cnt > 0 && !flush), m_ra);
            end
`ifdef FIFO_SYNC_CTRL_DROP_CNT_EN
            tests++; if (drop_cnt !== 16'(m_drop)) begin
                fails++; $display("FAIL rnd_drop cyc %0d: got %0d exp %0d", n, drop_cnt, m_drop);
            end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_pushpop();
        test_empty_pushpop();
        test_flush();
        test_async_reset();
`ifdef FIFO_SYNC_CTRL_DROP_CNT_EN
        test_drop();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
